// File: rtl/mem_miss_controller_pkg.sv
// Shared types and constants for the M-stage memory miss controller.
// Combinational only; no latency.
// No flow control.
package mem_ctrl_pkg;

  // Controller states; 3-bit encoding covers all seven.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_L2_ACCESS = 3'd1,
    ST_MM_READ   = 3'd2,
    ST_L2_FILL   = 3'd3,
    ST_L1_FILL   = 3'd4,
    ST_REPLAY    = 3'd5,
    ST_MM_WRITE  = 3'd6
  } mem_state_t;

  // Number of cycles the REPLAY state holds all status outputs low.
  localparam int REPLAY_HOLD = 1;

endpackage

// File: rtl/mem_miss_controller_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Count visible one cycle after the inc pulse.
// No backpressure; inc is a plain pulse.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Increment on inc unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_miss_controller.sv
// Control FSM sequencing L1 miss -> L2 lookup -> main memory -> L2/L1 refill, plus store write-through.
// Load hits complete in the same cycle; misses stall until refill, then one REPLAY cycle.
// Holds mem_stall high while busy; main-memory request held until mm_ack.
module mem_miss_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int L2_LATENCY = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  l1_hit,
  input  logic                  l2_hit,
  input  logic                  mm_ack,
  output logic                  mm_req,
  output logic                  mm_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  l2_fill_en,
  output logic                  l1_fill_en,
  output logic                  mem_stall,
  output logic                  l1_miss,
  output logic                  l2_miss,
  output logic                  cache_busy,
  output logic [CNT_WIDTH-1:0]  l1_miss_count,
  output logic [CNT_WIDTH-1:0]  l2_miss_count
);

  // Latency counter is shared between the L2 lookup wait and the REPLAY hold.
  localparam int LAT_MAX = (L2_LATENCY > REPLAY_HOLD) ? L2_LATENCY : REPLAY_HOLD;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT    = LAT_W'(L2_LATENCY);
  localparam logic [LAT_W-1:0] REPLAY_INIT = LAT_W'(REPLAY_HOLD - 1);

  mem_state_t            state, state_nxt;
  logic [LAT_W-1:0]      lat_cnt, lat_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  l1_inc, l2_inc;
  logic                  l2_last;

  // L2 lookup spans max(L2_LATENCY,1) cycles: the counter is loaded with
  // L2_LATENCY and l2_hit is sampled once it has counted down to 1, so a
  // latency of 0 samples on the very first L2_ACCESS cycle.
  assign l2_last = (lat_cnt <= LAT_W'(1));

  // State, latched miss address and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      fill_addr <= '0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_nxt;
      fill_addr <= addr_nxt;
    end
  end

  // Next-state and Moore/Mealy outputs; IDLE is the only state that looks at the M-stage request.
  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    addr_nxt   = fill_addr;
    mm_req     = 1'b0;
    mm_we      = 1'b0;
    l2_fill_en = 1'b0;
    l1_fill_en = 1'b0;
    mem_stall  = 1'b0;
    l1_miss    = 1'b0;
    l2_miss    = 1'b0;
    cache_busy = 1'b0;
    l1_inc     = 1'b0;
    l2_inc     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (mem_req) begin
          if (mem_we) begin
            // Write-through, no-allocate: every store goes to main memory.
            mem_stall = 1'b1;
            addr_nxt  = mem_addr;
            state_nxt = ST_MM_WRITE;
          end else if (!l1_hit) begin
            mem_stall = 1'b1;
            addr_nxt  = mem_addr;
            l1_inc    = 1'b1;
            lat_nxt   = LAT_INIT;
            state_nxt = ST_L2_ACCESS;
          end
        end
      end

      ST_L2_ACCESS: begin
        l1_miss   = 1'b1;
        mem_stall = 1'b1;
        if (l2_last) begin
          lat_nxt = '0;
          if (l2_hit) begin
            state_nxt = ST_L1_FILL;
          end else begin
            l2_inc    = 1'b1;
            state_nxt = ST_MM_READ;
          end
        end else begin
          lat_nxt = lat_cnt - 1'b1;
        end
      end

      ST_MM_READ: begin
        mm_req    = 1'b1;
        l1_miss   = 1'b1;
        l2_miss   = 1'b1;
        mem_stall = 1'b1;
        if (mm_ack) begin
          state_nxt = ST_L2_FILL;
        end
      end

      ST_L2_FILL: begin
        l2_fill_en = 1'b1;
        cache_busy = 1'b1;
        l1_miss    = 1'b1;
        mem_stall  = 1'b1;
        state_nxt  = ST_L1_FILL;
      end

      ST_L1_FILL: begin
        l1_fill_en = 1'b1;
        cache_busy = 1'b1;
        l1_miss    = 1'b1;
        mem_stall  = 1'b1;
        lat_nxt    = REPLAY_INIT;
        state_nxt  = ST_REPLAY;
      end

      ST_REPLAY: begin
        // Outputs all low so the held instruction retires; its inputs are not a new request.
        if (lat_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          lat_nxt = lat_cnt - 1'b1;
        end
      end

      ST_MM_WRITE: begin
        mm_req     = 1'b1;
        mm_we      = 1'b1;
        mem_stall  = 1'b1;
        cache_busy = 1'b1;
        if (mm_ack) begin
          lat_nxt   = REPLAY_INIT;
          state_nxt = ST_REPLAY;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_l1_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (l1_inc),
    .count (l1_miss_count)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_l2_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (l2_inc),
    .count (l2_miss_count)
  );

endmodule
